// File: rtl/pc_unit.sv
// pc_unit: program counter stage for the 16-bit CPU.
// Holds the current instruction address and supports increment, absolute jump, subroutine call
// and return. Return addresses live in an internal LIFO stack built from registers.
//
// Ports:
//   clk          system clock, rising-edge active
//   reset_n      synchronous active-low reset
//   inc          advance pc by 1
//   load         jump: pc <= addr_in
//   call         push pc+1, then pc <= addr_in
//   ret          pop: pc <= top of stack
//   addr_in      jump/call target
//   pc           current program counter (registered)
//   sp           number of valid stack entries, 0..DEPTH
//   stack_full   sp == DEPTH
//   stack_empty  sp == 0
//   stack_err    sticky flag: push on full or pop on empty was attempted
module pc_unit #(
   parameter int unsigned      WIDTH      = 16,
   parameter int unsigned      DEPTH      = 8,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     inc,
   input  logic                     load,
   input  logic                     call,
   input  logic                     ret,
   input  logic [WIDTH-1:0]         addr_in,
   output logic [WIDTH-1:0]         pc,
   output logic [$clog2(DEPTH):0]   sp,
   output logic                     stack_full,
   output logic                     stack_empty,
   output logic                     stack_err
);

   localparam int unsigned IDXW = $clog2(DEPTH);
   localparam int unsigned SPW  = IDXW + 1;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [SPW-1:0]   sp_q, sp_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] stack_q [DEPTH];

   logic [WIDTH-1:0] pc_plus1;
   logic [SPW-1:0]   sp_minus1;
   logic [IDXW-1:0]  push_idx;
   logic [IDXW-1:0]  pop_idx;
   logic             full;
   logic             empty;
   logic             push;

   assign pc_plus1  = pc_q + WIDTH'(1);   // wraps modulo 2^WIDTH
   assign sp_minus1 = sp_q - SPW'(1);
   assign push_idx  = sp_q[IDXW-1:0];
   assign pop_idx   = sp_minus1[IDXW-1:0];
   assign full      = (sp_q == SPW'(DEPTH));
   assign empty     = (sp_q == '0);

   // Priority: ret > call > load > inc > hold. Illegal stack ops only raise the error flag.
   always_comb begin
      pc_d  = pc_q;
      sp_d  = sp_q;
      err_d = err_q;
      push  = 1'b0;
      if (ret) begin
         if (empty) begin
            err_d = 1'b1;
         end else begin
            pc_d = stack_q[pop_idx];
            sp_d = sp_minus1;
         end
      end else if (call) begin
         if (full) begin
            err_d = 1'b1;
         end else begin
            push = 1'b1;
            pc_d = addr_in;
            sp_d = sp_q + SPW'(1);
         end
      end else if (load) begin
         pc_d = addr_in;
      end else if (inc) begin
         pc_d = pc_plus1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q  <= RESET_ADDR;
         sp_q  <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         err_q <= err_d;
      end
   end

   // Stack storage is not reset; entries above sp are unreachable. Reset suppresses the push.
   always_ff @(posedge clk) begin
      if (reset_n && push) begin
         stack_q[push_idx] <= pc_plus1;
      end
   end

   assign pc          = pc_q;
   assign sp          = sp_q;
   assign stack_full  = full;
   assign stack_empty = empty;
   assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        inc = 1'b0;
   logic        load = 1'b0;
   logic        call = 1'b0;
   logic        ret = 1'b0;
   logic [15:0] addr_in = '0;
   logic [15:0] pc;
   logic [3:0]  sp;
   logic        stack_full;
   logic        stack_empty;
   logic        stack_err;

   pc_unit #(
      .WIDTH      (16),
      .DEPTH      (8),
      .RESET_ADDR (16'h0000)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .inc         (inc),
      .load        (load),
      .call        (call),
      .ret         (ret),
      .addr_in     (addr_in),
      .pc          (pc),
      .sp          (sp),
      .stack_full  (stack_full),
      .stack_empty (stack_empty),
      .stack_err   (stack_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rn;
      logic        i;
      logic        l;
      logic        c;
      logic        r;
      logic [15:0] a;
      logic [15:0] exp_pc;
      logic [3:0]  exp_sp;
      logic        exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rn, input logic i, input logic l, input logic c,
                      input logic r, input logic [15:0] a, input logic [15:0] epc,
                      input logic [3:0] esp, input logic eerr);
      vec_t v;
      v.rn = rn; v.i = i; v.l = l; v.c = c; v.r = r; v.a = a;
      v.exp_pc = epc; v.exp_sp = esp; v.exp_err = eerr;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive controls mid-cycle, then sample 1 time unit after the rising edge.
   task automatic drive(input logic rn, input logic i, input logic l, input logic c,
                        input logic r, input logic [15:0] a);
      @(negedge clk);
      reset_n = rn; inc = i; load = l; call = c; ret = r; addr_in = a;
      @(posedge clk);
      #1;
      reset_n = 1'b1; inc = 1'b0; load = 1'b0; call = 1'b0; ret = 1'b0;
   endtask

   task automatic check_state(input string tag, input logic [15:0] epc, input logic [3:0] esp,
                              input logic eerr);
      chk({tag, " pc"}, pc, epc);
      chk({tag, " sp"}, {12'h0, sp}, {12'h0, esp});
      chk({tag, " full"}, {15'h0, stack_full}, {15'h0, (esp == 4'd8)});
      chk({tag, " empty"}, {15'h0, stack_empty}, {15'h0, (esp == 4'd0)});
      chk({tag, " err"}, {15'h0, stack_err}, {15'h0, eerr});
   endtask

   initial begin
      // rn inc load call ret addr    pc       sp  err
      // Reset, increment, wrap
      add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      add(1, 1, 0, 0, 0, 16'h0000, 16'h0001, 0, 0);
      add(1, 1, 0, 0, 0, 16'h0000, 16'h0002, 0, 0);
      add(1, 1, 0, 0, 0, 16'h0000, 16'h0003, 0, 0);
      add(1, 0, 1, 0, 0, 16'hFFFE, 16'hFFFE, 0, 0);
      add(1, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 0);
      add(1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      // Call / inc / ret, with a hold cycle
      add(1, 0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0);
      add(1, 0, 0, 0, 0, 16'h0ABC, 16'h0010, 0, 0);
      add(1, 0, 0, 1, 0, 16'h0200, 16'h0200, 1, 0);
      add(1, 1, 0, 0, 0, 16'h0000, 16'h0201, 1, 0);
      add(1, 1, 0, 0, 0, 16'h0000, 16'h0202, 1, 0);
      add(1, 0, 0, 0, 1, 16'h0000, 16'h0011, 0, 0);
      // Pop on empty: sticky error until reset
      add(1, 0, 1, 0, 0, 16'h0042, 16'h0042, 0, 0);
      add(1, 0, 0, 0, 1, 16'h0000, 16'h0042, 0, 1);
      add(1, 1, 0, 0, 0, 16'h0000, 16'h0043, 0, 1);
      add(1, 0, 0, 1, 0, 16'h0300, 16'h0300, 1, 1);
      add(1, 0, 0, 0, 1, 16'h0000, 16'h0044, 0, 1);
      add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
      // Simultaneous controls
      add(1, 0, 1, 0, 0, 16'h0032, 16'h0032, 0, 0);
      add(1, 0, 0, 1, 0, 16'h0400, 16'h0400, 1, 0);
      add(1, 1, 1, 1, 1, 16'h0777, 16'h0033, 0, 0);
      add(1, 1, 1, 0, 0, 16'h1234, 16'h1234, 0, 0);
      add(1, 1, 1, 1, 0, 16'h0050, 16'h0050, 1, 0);
      add(1, 0, 0, 0, 1, 16'h0000, 16'h1235, 0, 0);
      // Call from 0xFFFF pushes the wrapped return address
      add(1, 0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0, 0);
      add(1, 0, 0, 1, 0, 16'h0600, 16'h0600, 1, 0);
      add(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
      // Reset mid-operation discards the stack and suppresses the push
      add(1, 0, 1, 0, 0, 16'h0100, 16'h0100, 0, 0);
      add(1, 0, 0, 1, 0, 16'h0200, 16'h0200, 1, 0);
      add(1, 0, 0, 1, 0, 16'h0300, 16'h0300, 2, 0);
      add(1, 0, 0, 1, 0, 16'h0456, 16'h0456, 3, 0);
      add(0, 0, 0, 1, 0, 16'h0999, 16'h0000, 0, 0);
      add(1, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 1);
      add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);

      for (int n = 0; n < vecs.size(); n++) begin
         drive(vecs[n].rn, vecs[n].i, vecs[n].l, vecs[n].c, vecs[n].r, vecs[n].a);
         check_state($sformatf("vec%0d", n), vecs[n].exp_pc, vecs[n].exp_sp, vecs[n].exp_err);
      end

      // Nested calls to full depth, overflow, then unwind
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 0, 1, 0, 16'h0100 + 16'(k));
         check_state($sformatf("nest_call%0d", k), 16'h0100 + 16'(k), 4'(k + 1), 1'b0);
      end
      drive(1, 0, 0, 1, 0, 16'h0500);
      check_state("overflow_call", 16'h0107, 4'd8, 1'b1);
      for (int k = 7; k >= 1; k--) begin
         drive(1, 0, 0, 0, 1, 16'h0000);
         check_state($sformatf("nest_ret%0d", k), 16'h0100 + 16'(k), 4'(k), 1'b1);
      end
      drive(1, 0, 0, 0, 1, 16'h0000);
      check_state("nest_ret0", 16'h0001, 4'd0, 1'b1);
      drive(1, 0, 0, 0, 1, 16'h0000);
      check_state("underflow_ret", 16'h0001, 4'd0, 1'b1);
      drive(0, 0, 0, 0, 0, 16'h0000);
      check_state("final_reset", 16'h0000, 4'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program counter stage for the 16-bit CPU. It holds the current instruction address and drives the address input of the instruction memory.
- Supports increment, absolute jump, subroutine call and return.
- Call/return use an internal return-address stack (LIFO) built from 16-bit register storage.
- All state updates occur on the rising clock edge.

Parameters:
WIDTH, 16, address/data width of pc and stack entries
DEPTH, 8, number of return-stack entries (power of 2, >=2)
RESET_ADDR, 16'h0000, value loaded into pc on reset

Ports:
clk  input  1  system clock, rising-edge active
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
inc  input  1  advance pc by 1
load  input  1  jump: pc <= addr_in
call  input  1  push pc+1, then pc <= addr_in
ret  input  1  pop: pc <= top of stack
addr_in  input  WIDTH  jump/call target
pc  output  WIDTH  current program counter
sp  output  $clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH
stack_full  output  1  sp == DEPTH
stack_empty  output  1  sp == 0
stack_err  output  1  sticky: illegal push or pop attempted

Behaviour:
- Reset: reset_n sampled low at a rising edge gives pc=RESET_ADDR, sp=0, stack_err=0. The result is visible after that edge.
  - Reset has top priority and overrides any control input in the same cycle.
  - Reset asserted mid-operation discards the entire stack. Stack contents need not be cleared, but they are unreachable because sp=0.
- Before the first reset, outputs are undefined. The bench must apply reset first.
- Priority when several controls are high in one cycle: reset > ret > call > load > inc > hold. Exactly one action is taken per cycle.
- All actions have 1-cycle latency: the new pc is visible after the edge that samples the control.
- inc: pc <= pc+1 modulo 2^WIDTH, so 16'hFFFF wraps to 16'h0000.
- load: pc <= addr_in. The stack is unchanged.
- call, when sp<DEPTH:
  - stack[sp] <= pc+1, with the same wrap rule as inc;
  - sp <= sp+1;
  - pc <= addr_in.
- call when full (sp==DEPTH) is illegal: pc, sp and stack stay unchanged, and stack_err <= 1.
- ret, when sp>0: pc <= stack[sp-1] and sp <= sp-1.
- ret when empty (sp==0) is illegal: pc and sp stay unchanged, and stack_err <= 1.
- stack_err is sticky and is cleared only by reset.
- No control asserted: pc, sp and stack hold.
- stack_full and stack_empty are combinational decodes of registered sp and carry no extra latency. After reset, stack_empty=1 and stack_full=0.
- Back-to-back operations are allowed every cycle, for example a call followed by a ret on the next cycle returns to the caller's pc+1.
- The pc output is driven directly from a register, with no combinational path from inputs.

Test Plan:
1. Reset, then inc held high for 3 cycles -> pc sequence 0,1,2,3. Then force pc via load addr_in=16'hFFFE and inc for 2 cycles -> pc 16'hFFFE, 16'hFFFF, 16'h0000.
2. At pc=16'h0010, call addr_in=16'h0200, then inc twice, then ret -> pc sequence 16'h0200, 16'h0201, 16'h0202, 16'h0011. sp goes 1 then 0; stack_empty=1 at the end; stack_err=0.
3. Nested calls: 8 calls from pc 16'h0000 with targets 16'h0100..16'h0107 -> sp=8 and stack_full=1. A 9th call to 16'h0500 leaves pc=16'h0107 and sets stack_err=1. Then 8 rets -> pc values 16'h0105+1=16'h0106? No: return addresses pop in order 16'h0107, 16'h0106, ..., 16'h0101, 16'h0001, each being the caller pc+1. Final sp=0.
4. ret at sp=0 with pc=16'h0042 -> pc stays 16'h0042, sp=0, stack_err=1. stack_err stays 1 through later legal operations until reset_n=0 is applied for one edge, after which stack_err=0.
5. Simultaneous controls: ret+call+load+inc in one cycle with sp=1 and top entry=16'h0033 -> pc=16'h0033 and sp=0. load+inc with addr_in=16'h1234 -> pc=16'h1234.
6. Reset mid-operation: from sp=3, pc=16'h0456, assert reset_n=0 together with call -> pc=16'h0000, sp=0, stack_empty=1, with no push. A subsequent ret sets stack_err=1.
